// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types for the dmlb miss-replay slice
// Purpose: miss-queue entry layout, replay FSM states, walk key width and
// the page-number helper used for duplicate detection and walk keys.
// Ports: none (package).
package lsu_pkg;

    localparam int WALK_KEY_WIDTH  = 52;
    localparam int DMLB_DATA_WIDTH = 64;

    typedef struct packed {
        logic [43:0] addr;
        logic [3:0]  attr;
        logic        thread;
    } miss_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        WWAIT,
        REPLAY,
        DRAIN
    } replay_state_t;

    // Page number as used in the MLB lookup key (8 KiB pages).
    function automatic logic [30:0] page_of(input logic [43:0] addr);
        return addr[43:13];
    endfunction

endpackage

// File: rtl/dmlb_miss_fifo.sv
// rtl/dmlb_miss_fifo.sv - miss queue with page+thread compare across live entries
// Purpose: FIFO of pending MLB misses. cmp_hit reports whether any live entry
// (the head included) matches cmp_page/cmp_thread.
// Ports: clk, rst (sync, active-high), clr (flush), push/push_data, pop,
//        head, empty, full, cmp_page/cmp_thread -> cmp_hit.
module dmlb_miss_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  miss_entry_t push_data,
    input  logic        pop,
    output miss_entry_t head,
    output logic        empty,
    output logic        full,
    input  logic [30:0] cmp_page,
    input  logic        cmp_thread,
    output logic        cmp_hit
);

    localparam int AW = $clog2(DEPTH);

    miss_entry_t      mem [DEPTH];
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      count;
    logic [DEPTH-1:0] hit;

    // Extra MSB on the pointers separates full from empty.
    assign count = wr_ptr - rd_ptr;
    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A slot is live when its distance from the read pointer is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cam
        logic [AW-1:0] offs;
        assign offs   = AW'(g) - rd_ptr[AW-1:0];
        assign hit[g] = ({1'b0, offs} < count)
                        && (page_of(mem[g].addr) == cmp_page)
                        && (mem[g].thread == cmp_thread);
    end

    assign cmp_hit = |hit;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dmlb_miss_replay.sv
// rtl/dmlb_miss_replay.sv - MLB miss capture, page-walk serialisation and replay probe
// Purpose: queues address-calc MLB misses, walks them one at a time, fills the
// data MLB and re-issues the faulting address on mex_* so address-calc re-looks-up.
// Ports: miss_* (capture) / miss_retry, walk_* (page walker), proc (process id),
//        mlb_* (fill), bus_hold/mex_* (replay probe), fault_* (walk fault),
//        except (flush), busy.
module dmlb_miss_replay
    import lsu_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int MLB_DATA_WIDTH = DMLB_DATA_WIDTH,
    parameter int PADDR_WIDTH    = 44
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      except,
    input  logic                      miss_en,
    input  logic [PADDR_WIDTH-1:0]    miss_addr,
    input  logic [3:0]                miss_attr,
    input  logic                      miss_thread,
    output logic                      miss_retry,
    output logic                      walk_req,
    output logic [WALK_KEY_WIDTH-1:0] walk_addr,
    output logic [3:0]                walk_attr,
    output logic                      walk_thread,
    input  logic                      walk_ack,
    input  logic                      walk_done,
    input  logic                      walk_fault,
    input  logic [MLB_DATA_WIDTH-1:0] walk_data,
    input  logic [23:0]               proc,
    output logic                      mlb_wen,
    output logic [WALK_KEY_WIDTH-1:0] mlb_waddr,
    output logic [MLB_DATA_WIDTH-1:0] mlb_wdata,
    input  logic                      bus_hold,
    output logic                      mex_en,
    output logic [PADDR_WIDTH-1:0]    mex_addr,
    output logic [3:0]                mex_attr,
    output logic                      fault_en,
    output logic [PADDR_WIDTH-1:0]    fault_addr,
    output logic                      busy
);

    replay_state_t             state;
    miss_entry_t               head;
    miss_entry_t               new_entry;
    logic                      empty;
    logic                      full;
    logic                      dup;
    logic                      push;
    logic                      pop;
    logic                      walk_live;
    logic                      done_live;
    logic [WALK_KEY_WIDTH-1:0] key_q;
    logic [WALK_KEY_WIDTH-1:0] cur_key;
    logic                      unused_proc_hi;

    assign unused_proc_hi = ^proc[23:21];
    assign new_entry      = '{addr: miss_addr, attr: miss_attr, thread: miss_thread};

    // proc is only trusted while WREQ; the key is latched at walk_ack for the fill.
    assign cur_key = (state == WREQ) ? {proc[20:0], page_of(head.addr)} : key_q;

    // A done counts while waiting, or in the very cycle the walker accepts.
    assign walk_live = ((state == WREQ) && walk_ack) || (state == WWAIT);
    assign done_live = walk_live && walk_done && !except;

    assign mlb_wen  = done_live && !walk_fault;
    assign fault_en = done_live && walk_fault;
    assign mex_en   = (state == REPLAY) && !bus_hold && !except;
    assign pop      = fault_en || mex_en;

    // A full queue still takes a miss when the head leaves in the same cycle.
    assign push = miss_en && !except && !dup && (!full || pop);

    assign walk_req    = (state == WREQ);
    assign walk_addr   = walk_req ? cur_key : '0;
    assign walk_attr   = walk_req ? head.attr : '0;
    assign walk_thread = walk_req ? head.thread : 1'b0;
    assign mlb_waddr   = mlb_wen ? cur_key : '0;
    assign mlb_wdata   = mlb_wen ? walk_data : '0;
    assign mex_addr    = (state == REPLAY) ? head.addr : '0;
    assign mex_attr    = (state == REPLAY) ? head.attr : '0;
    assign fault_addr  = fault_en ? head.addr : '0;

    dmlb_miss_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (except),
        .push       (push),
        .push_data  (new_entry),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .cmp_page   (page_of(miss_addr)),
        .cmp_thread (miss_thread),
        .cmp_hit    (dup)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_q      <= '0;
            busy       <= 1'b0;
            miss_retry <= 1'b0;
        end else begin
            busy       <= !empty || (state != IDLE);
            miss_retry <= miss_en && !except && !dup && full && !pop;
            if ((state == WREQ) && walk_ack) key_q <= cur_key;
            case (state)
                IDLE: begin
                    if (!except && !empty) state <= WREQ;
                end
                WREQ: begin
                    // An accepted walk that is flushed must still be drained.
                    if (except)        state <= (walk_ack && !walk_done) ? DRAIN : IDLE;
                    else if (walk_ack) state <= walk_done ? (walk_fault ? IDLE : REPLAY) : WWAIT;
                end
                WWAIT: begin
                    if (except)         state <= walk_done ? IDLE : DRAIN;
                    else if (walk_done) state <= walk_fault ? IDLE : REPLAY;
                end
                REPLAY: begin
                    if (except || !bus_hold) state <= IDLE;
                end
                DRAIN: begin
                    if (walk_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmlb_miss_replay.sv
// tb/tb_dmlb_miss_replay.sv - directed self-checking bench for dmlb_miss_replay
module tb_dmlb_miss_replay;

    logic        clk = 1'b0;
    logic        rst;
    logic        except;
    logic        miss_en;
    logic [43:0] miss_addr;
    logic [3:0]  miss_attr;
    logic        miss_thread;
    logic        miss_retry;
    logic        walk_req;
    logic [51:0] walk_addr;
    logic [3:0]  walk_attr;
    logic        walk_thread;
    logic        walk_ack;
    logic        walk_done;
    logic        walk_fault;
    logic [63:0] walk_data;
    logic [23:0] proc;
    logic        mlb_wen;
    logic [51:0] mlb_waddr;
    logic [63:0] mlb_wdata;
    logic        bus_hold;
    logic        mex_en;
    logic [43:0] mex_addr;
    logic [3:0]  mex_attr;
    logic        fault_en;
    logic [43:0] fault_addr;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    dmlb_miss_replay #(
        .DEPTH          (4),
        .MLB_DATA_WIDTH (64),
        .PADDR_WIDTH    (44)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .except      (except),
        .miss_en     (miss_en),
        .miss_addr   (miss_addr),
        .miss_attr   (miss_attr),
        .miss_thread (miss_thread),
        .miss_retry  (miss_retry),
        .walk_req    (walk_req),
        .walk_addr   (walk_addr),
        .walk_attr   (walk_attr),
        .walk_thread (walk_thread),
        .walk_ack    (walk_ack),
        .walk_done   (walk_done),
        .walk_fault  (walk_fault),
        .walk_data   (walk_data),
        .proc        (proc),
        .mlb_wen     (mlb_wen),
        .mlb_waddr   (mlb_waddr),
        .mlb_wdata   (mlb_wdata),
        .bus_hold    (bus_hold),
        .mex_en      (mex_en),
        .mex_addr    (mex_addr),
        .mex_attr    (mex_attr),
        .fault_en    (fault_en),
        .fault_addr  (fault_addr),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic [43:0] a, input logic [3:0] at);
        miss_en   = 1'b1;
        miss_addr = a;
        miss_attr = at;
        tick();
        miss_en   = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!walk_req && n < 30) begin
            tick();
            n++;
        end
        check(tag, walk_req, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_walk_req"},   walk_req,   0);
        check({tag, "_walk_addr"},  walk_addr,  0);
        check({tag, "_mlb_wen"},    mlb_wen,    0);
        check({tag, "_mlb_waddr"},  mlb_waddr,  0);
        check({tag, "_mlb_wdata"},  mlb_wdata,  0);
        check({tag, "_mex_en"},     mex_en,     0);
        check({tag, "_mex_addr"},   mex_addr,   0);
        check({tag, "_fault_en"},   fault_en,   0);
        check({tag, "_fault_addr"}, fault_addr, 0);
        check({tag, "_miss_retry"}, miss_retry, 0);
        check({tag, "_busy"},       busy,       0);
    endtask

    logic [43:0] t2_addr [7];
    logic [43:0] a_g, a_h, a_m, a_n;
    bit          seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; except = 1'b0; miss_en = 1'b0; miss_addr = '0; miss_attr = '0;
        miss_thread = 1'b0; walk_ack = 1'b0; walk_done = 1'b0; walk_fault = 1'b0;
        walk_data = '0; proc = 24'hABCDEF; bus_hold = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_quiet("reset");

        // Test 1: single miss, ack at cycle 3, done at cycle 6.
        for (int c = 0; c < 10; c++) begin
            miss_en   = (c == 0);
            miss_addr = 44'h0_1234_5678;
            miss_attr = 4'h5;
            walk_ack  = (c == 3);
            walk_done = (c == 6);
            walk_data = 64'hDEAD_BEEF_0000_1111;
            #2;
            check($sformatf("t1_walk_req_c%0d", c), walk_req, (c == 2 || c == 3));
            check($sformatf("t1_mlb_wen_c%0d", c),  mlb_wen,  (c == 6));
            check($sformatf("t1_mex_en_c%0d", c),   mex_en,   (c == 7));
            check($sformatf("t1_busy_c%0d", c),     busy,     (c >= 2 && c <= 8));
            if (c == 2) begin
                check("t1_walk_addr", walk_addr, {21'h0BCDEF, 31'h91A2});
                check("t1_walk_attr", walk_attr, 4'h5);
            end
            if (c == 6) begin
                check("t1_mlb_waddr", mlb_waddr, {21'h0BCDEF, 31'h91A2});
                check("t1_mlb_wdata", mlb_wdata, 64'hDEAD_BEEF_0000_1111);
            end
            if (c == 7) begin
                check("t1_mex_addr", mex_addr, 44'h0_1234_5678);
                check("t1_mex_attr", mex_attr, 4'h5);
            end
            tick();
        end
        miss_en = 1'b0; walk_ack = 1'b0; walk_done = 1'b0;

        // Test 2: pages 1..4 fill the queue, repeat of page 1 dropped, pages 5,6 retried.
        t2_addr = '{44'h2055, 44'h4055, 44'h6055, 44'h8055, 44'h2123, 44'hA055, 44'hC055};
        for (int c = 0; c < 9; c++) begin
            miss_en   = (c < 7);
            miss_addr = (c < 7) ? t2_addr[c] : 44'h0;
            miss_attr = 4'h1;
            #2;
            check($sformatf("t2_retry_c%0d", c), miss_retry, (c == 6 || c == 7));
            tick();
        end
        miss_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wait_req($sformatf("t2_req%0d", k));
            check($sformatf("t2_page%0d", k), walk_addr[30:0], k);
            walk_ack = 1'b1; walk_done = 1'b1; walk_data = 64'(k);
            #1;
            check($sformatf("t2_wen%0d", k), mlb_wen, 1);
            check($sformatf("t2_wpage%0d", k), mlb_waddr[30:0], k);
            tick();
            walk_ack = 1'b0; walk_done = 1'b0;
            #1;
            check($sformatf("t2_mex%0d", k), mex_en, 1);
            check($sformatf("t2_mex_addr%0d", k), mex_addr, t2_addr[k-1]);
            tick();
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (walk_req) seen = 1'b1;
            tick();
        end
        check("t2_no_extra_walk", seen, 0);
        check("t2_busy_idle", busy, 0);

        // Test 3: fault on G, then H's walk two cycles later. Test 4: bus_hold on H.
        a_g = 44'h0_0000_E0AA;
        a_h = 44'h0_0001_0077;
        miss(a_g, 4'h3);
        miss(a_h, 4'h9);
        wait_req("t3_req_g");
        check("t3_page_g", walk_addr[30:0], 7);
        walk_ack = 1'b1;
        tick();
        walk_ack = 1'b0;
        tick();
        walk_done = 1'b1; walk_fault = 1'b1;
        #1;
        check("t3_fault_en", fault_en, 1);
        check("t3_fault_addr", fault_addr, a_g);
        check("t3_no_wen", mlb_wen, 0);
        tick();
        walk_done = 1'b0; walk_fault = 1'b0;
        #1;
        check("t3_fault_one_cycle", fault_en, 0);
        check("t3_no_mex", mex_en, 0);
        check("t3_req_f1", walk_req, 0);
        tick();
        check("t3_req_f2", walk_req, 1);
        check("t3_page_h", walk_addr[30:0], 8);
        walk_ack = 1'b1;
        tick();
        walk_ack = 1'b0;
        walk_done = 1'b1; walk_data = 64'h55;
        #1;
        check("t4_wen", mlb_wen, 1);
        tick();
        walk_done = 1'b0;
        for (int h = 0; h < 5; h++) begin
            bus_hold = (h < 3);
            #1;
            check($sformatf("t4_mex_en_h%0d", h), mex_en, (h == 3));
            if (h <= 3) begin
                check($sformatf("t4_mex_addr_h%0d", h), mex_addr, a_h);
                check($sformatf("t4_mex_attr_h%0d", h), mex_attr, 4'h9);
            end
            tick();
        end
        bus_hold = 1'b0;

        // Test 5: except while waiting with two more queued, plus a miss in the except cycle.
        miss(44'h0_0001_2000, 4'h2);
        miss(44'h0_0001_4000, 4'h2);
        miss(44'h0_0001_6000, 4'h2);
        wait_req("t5_req");
        walk_ack = 1'b1;
        tick();
        walk_ack = 1'b0;
        except = 1'b1;
        miss_en = 1'b1; miss_addr = 44'h0_0001_8000;
        #1;
        check("t5_exc_no_wen", mlb_wen, 0);
        tick();
        except = 1'b0; miss_en = 1'b0;
        #1;
        check("t5_drain_no_req", walk_req, 0);
        check("t5_drain_busy", busy, 1);
        tick(); tick(); tick();
        walk_done = 1'b1;
        #1;
        check("t5_done_no_wen", mlb_wen, 0);
        check("t5_done_no_fault", fault_en, 0);
        tick();
        walk_done = 1'b0;
        tick();
        check("t5_busy_clear", busy, 0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (walk_req || mex_en) seen = 1'b1;
            tick();
        end
        check("t5_queue_flushed", seen, 0);

        // Test 6: reset in REPLAY, then a fresh miss.
        a_m = 44'h0_0001_A011;
        a_n = 44'h0_0001_C022;
        miss(a_m, 4'h4);
        wait_req("t6_req_m");
        walk_ack = 1'b1; walk_done = 1'b1;
        tick();
        walk_ack = 1'b0; walk_done = 1'b0;
        bus_hold = 1'b1;
        #1;
        check("t6_hold_mex", mex_en, 0);
        check("t6_hold_addr", mex_addr, a_m);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_hold = 1'b0;
        #1;
        check_quiet("t6_after_rst");
        miss(a_n, 4'h6);
        wait_req("t6_req_n");
        check("t6_page_n", walk_addr[30:0], 14);
        walk_ack = 1'b1; walk_done = 1'b1;
        tick();
        walk_ack = 1'b0; walk_done = 1'b0;
        #1;
        check("t6_mex_n", mex_en, 1);
        check("t6_mex_addr_n", mex_addr, a_n);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmlb_miss_replay.md
Name: dmlb_miss_replay

Overview:
- Other end of the store address pipe's `mex_*` interface.
- Captures MLB misses reported by the address-calc stage and serialises them to the page walker.
- Writes each returned translation into the data MLB, then re-issues the faulting address as a `mex_en`/`mex_addr`/`mex_attr` probe so the address-calc stage re-looks-up and confirms the hit.
- Sits between the LSU address-calc stages, the dmlb arrays and the page-walk unit.

Parameters:
- DEPTH, 4, miss queue entries; power of two, minimum 2.
- MLB_DATA_WIDTH, `dmlbData_width, width of a translation fill word.
- PADDR_WIDTH, 44, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- except  in  1  pipeline flush; discards all queued and in-flight misses.
- miss_en  in  1  MLB miss strobe from address-calc.
- miss_addr  in  44  virtual address of the miss.
- miss_attr  in  4  attribute nibble of the missing op.
- miss_thread  in  1  thread of the missing op.
- miss_retry  out  1  miss dropped because the queue was full; the LSQ must replay the op.
- walk_req  out  1  page-walk request valid.
- walk_addr  out  52  {proc[20:0], addr[43:13]}, same packing as the MLB lookup key.
- walk_attr  out  4  attributes of the head entry.
- walk_thread  out  1  thread of the head entry.
- walk_ack  in  1  walker accepted the request.
- walk_done  in  1  walk result valid.
- walk_fault  in  1  walk terminated with a fault.
- walk_data  in  MLB_DATA_WIDTH  translation for the MLB fill.
- proc  in  24  current process id for the head entry's thread.
- mlb_wen  out  1  MLB fill write strobe.
- mlb_waddr  out  52  fill key; equals walk_addr of the head entry.
- mlb_wdata  out  MLB_DATA_WIDTH  fill data.
- bus_hold  in  1  address-calc slot not available this cycle.
- mex_en  out  1  replay probe valid.
- mex_addr  out  44  replay address.
- mex_attr  out  4  replay attributes.
- fault_en  out  1  one-cycle pulse: walk faulted for the head entry.
- fault_addr  out  44  faulting virtual address; valid with fault_en.
- busy  out  1  queue non-empty or FSM not IDLE.

Behaviour:
- Reset: queue empty; FSM = IDLE. All outputs 0: walk_req, mlb_wen, mex_en, fault_en, miss_retry, busy; all address and data outputs 0.
- Enqueue (cycle N, registered):
  - Entry is {addr, attr, thread}.
  - Dropped silently (no retry) if a valid entry, or the in-flight head, has the same addr[43:13] and thread.
  - If the queue is full and the miss is not a duplicate: not enqueued; miss_retry=1 in cycle N+1 for one cycle.
  - Enqueue while the head pops in the same cycle is allowed when full: the pop happens first.
- Pointer wrap: rd_ptr/wr_ptr are log2(DEPTH)+1 bits.
  - Full = pointers equal except MSB.
  - Empty = pointers fully equal.
- FSM:
  - IDLE: queue non-empty -> WREQ next cycle. Earliest walk_req is cycle N+2 for a miss at cycle N into an empty queue.
  - WREQ: walk_req=1, walk_addr/attr/thread from the head, held stable until walk_ack. On walk_ack -> WWAIT.
  - WWAIT: on walk_done:
    - walk_fault=1: fault_en and fault_addr for one cycle, pop head, -> IDLE.
    - Otherwise: mlb_wen=1 for one cycle with the head key and walk_data, -> REPLAY.
    - walk_done in the same cycle as walk_ack is accepted: the FSM goes WREQ -> WWAIT and handles the done in the same cycle.
  - REPLAY: mex_en=1 with the head addr/attr in the first cycle where bus_hold=0. Head pops that cycle; -> IDLE. While bus_hold=1, mex_en=0 and mex_addr/mex_attr hold.
  - DRAIN: entered on except while in WWAIT. Waits for walk_done; result discarded (no mlb_wen, no fault_en). -> IDLE.
- except:
  - Clears the queue in the same cycle.
  - Misses arriving in the except cycle are discarded.
  - From WREQ: walk_req drops next cycle unless walk_ack is seen in the except cycle, in which case -> DRAIN.
  - From WWAIT: -> DRAIN. If walk_done is in the except cycle: result discarded, -> IDLE.
  - From REPLAY: -> IDLE, no mex_en issued.
- Ordering: strict FIFO with one walk outstanding.
- proc is sampled combinationally while in WREQ; the caller muxes it by walk_thread.
- busy is registered.

Decomposition:
- lsu_pkg:
  - miss entry struct {addr[43:0], attr[3:0], thread}.
  - FSM state enum {IDLE, WREQ, WWAIT, REPLAY, DRAIN}.
  - walk key width constant 52.
- Sub-module `dmlb_miss_fifo`: parametrised FIFO with a page+thread CAM-compare output used for duplicate detection.

Test Plan:
1. Single miss: miss_addr=44'h0_1234_5678 at cycle 0, walk_ack at cycle 3, walk_done at cycle 6 -> walk_req at cycles 2-3; mlb_wen at cycle 6 with key low bits = 44'h0_1234_5678>>13; mex_en at cycle 7 with mex_addr=44'h0_1234_5678; busy=0 at cycle 9.
2. Duplicate and full: 6 misses to distinct pages plus one repeat of the first page, DEPTH=4, walker stalled -> 4 enqueued; retry pulses for misses 5 and 6; the repeat causes no retry and no second walk.
3. Fault: walk_done with walk_fault=1 -> fault_en one cycle with fault_addr=head addr; no mlb_wen; no mex_en; next entry's walk_req follows 2 cycles later.
4. bus_hold: REPLAY with bus_hold=1 for 3 cycles -> mex_en stays 0, then 1 for exactly one cycle in cycle 4 with stable address.
5. except in WWAIT with 2 queued -> queue empty next cycle; walk_done 5 cycles later produces no mlb_wen or fault_en; FSM returns to IDLE; busy=0.
6. Reset mid-REPLAY -> all outputs 0 next cycle; a new miss after reset is processed normally.
